// File: rtl/simd_wb_scheduler_if.sv
// Issue/writeback handshake between the register-read stage, the SIMD unit and its
// writeback scheduler. Clock and reset stay outside as plain ports.
interface simd_wb_scheduler_if #(
   parameter int TAG_W = 7,
   parameter int CNT_W = 32
);
   logic             flush_i;
   logic             issue_valid_i;
   logic             issue_is_vmul_i;
   logic             issue_is_vred_i;
   logic [1:0]       issue_sew_i;
   logic [TAG_W-1:0] issue_tag_i;
   logic             issue_ready_o;
   logic             wb_valid_o;
   logic [1:0]       wb_sel_o;
   logic [TAG_W-1:0] wb_tag_o;
   logic             busy_o;
   logic [1:0]       inflight_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output flush_i,
      output issue_valid_i,
      output issue_is_vmul_i,
      output issue_is_vred_i,
      output issue_sew_i,
      output issue_tag_i,
      input  issue_ready_o,
      input  wb_valid_o,
      input  wb_sel_o,
      input  wb_tag_o,
      input  busy_o,
      input  inflight_o,
      input  stall_cnt_o
   );

   modport slave (
      input  flush_i,
      input  issue_valid_i,
      input  issue_is_vmul_i,
      input  issue_is_vred_i,
      input  issue_sew_i,
      input  issue_tag_i,
      output issue_ready_o,
      output wb_valid_o,
      output wb_sel_o,
      output wb_tag_o,
      output busy_o,
      output inflight_o,
      output stall_cnt_o
   );
endinterface

// File: rtl/simd_wb_scheduler.sv
// Writeback-slot scheduler for the SIMD unit: derives op latency (1/2/3), reserves the
// shared result port and back-pressures issue when the needed slot is already taken.
module simd_wb_scheduler #(
   parameter int TAG_W = 7,
   parameter int CNT_W = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   simd_wb_scheduler_if.slave bus
);

   function automatic logic [1:0] op_latency(input logic is_vmul, input logic is_vred,
                                             input logic [1:0] sew);
      logic [1:0] lat;
      lat = 2'd1;
      if (is_vmul) lat = (sew == 2'b11) ? 2'd3 : 2'd2;
      else if (is_vred) lat = 2'd2;
      return lat;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [1:0]       lat_p0;
   logic             slot_busy_p0;
   logic             ready_p0;
   logic             acc_p0;
   logic             acc_l2_p0;
   logic             acc_l3_p0;
   logic             vld_p1;
   logic             vld_p2;
   logic [TAG_W-1:0] tag_p1;
   logic [TAG_W-1:0] tag_p2;
   logic [1:0]       sel_p1;
   logic [1:0]       occ;
   logic [CNT_W-1:0] stall_cnt;
   logic             wb_valid;
   logic [1:0]       wb_sel;
   logic [TAG_W-1:0] wb_tag;

   // occ[0]: an older op owns the port this cycle; occ[1]: it owns the port next cycle
   assign occ = {vld_p2, vld_p1};

   // ---- p0: issue decode and slot check ----
   always_comb begin
      lat_p0       = op_latency(bus.issue_is_vmul_i, bus.issue_is_vred_i, bus.issue_sew_i);
      slot_busy_p0 = 1'b0;
      case (lat_p0)
         2'd1:    slot_busy_p0 = occ[0];
         2'd2:    slot_busy_p0 = occ[1];
         default: slot_busy_p0 = 1'b0;
      endcase
      ready_p0  = !rst_i && !bus.flush_i && !slot_busy_p0;
      acc_p0    = bus.issue_valid_i && ready_p0;
      acc_l2_p0 = acc_p0 && (lat_p0 == 2'd2);
      acc_l3_p0 = acc_p0 && (lat_p0 == 2'd3);
   end

   // Older in-flight op always wins; a same-cycle op only writes back when the port is free.
   always_comb begin
      wb_valid = 1'b0;
      wb_sel   = 2'd0;
      wb_tag   = '0;
      if (!rst_i && !bus.flush_i) begin
         if (vld_p1) begin
            wb_valid = 1'b1;
            wb_sel   = sel_p1;
            wb_tag   = tag_p1;
         end else if (acc_p0 && (lat_p0 == 2'd1)) begin
            wb_valid = 1'b1;
            wb_sel   = 2'd0;
            wb_tag   = bus.issue_tag_i;
         end
      end
   end

   // ---- p1/p2: in-flight entries ----
   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush_i) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= vld_p2 || acc_l2_p0;
         vld_p2 <= acc_l3_p0;
      end
   end

   // Payload needs no reset: it is only observed through the valid bits above.
   always_ff @(posedge clk_i) begin
      if (vld_p2) begin
         tag_p1 <= tag_p2;
         sel_p1 <= 2'd2;
      end else if (acc_l2_p0) begin
         tag_p1 <= bus.issue_tag_i;
         sel_p1 <= 2'd1;
      end
      if (acc_l3_p0) tag_p2 <= bus.issue_tag_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) stall_cnt <= '0;
      else if (bus.issue_valid_i && !ready_p0 && !bus.flush_i) stall_cnt <= sat_inc(stall_cnt);
   end

   assign bus.issue_ready_o = ready_p0;
   assign bus.wb_valid_o    = wb_valid;
   assign bus.wb_sel_o      = wb_sel;
   assign bus.wb_tag_o      = wb_tag;
   assign bus.busy_o        = vld_p1 || vld_p2;
   assign bus.inflight_o    = {1'b0, vld_p1} + {1'b0, vld_p2};
   assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_simd_wb_scheduler.sv
// Scenario bench for simd_wb_scheduler: expected writebacks are queued at issue time and
// matched against the result port by a monitor; each scenario also checks status inline.
module tb_simd_wb_scheduler;
   localparam int TAG_W = 7;
   localparam int CNT_W = 32;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [1:0]       sel;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   mon_en = 1'b0;
   exp_t q[$];

   simd_wb_scheduler_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   simd_wb_scheduler #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.wb_valid_o) begin
            n_total++;
            if (q.size() == 0) begin
               $display("FAIL wb_unexpected: got tag %0d sel %0d at cycle %0d, expected no writeback",
                        bus.wb_tag_o, bus.wb_sel_o, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (bus.wb_tag_o !== e.tag || bus.wb_sel_o !== e.sel || cyc != e.cyc)
                  $display("FAIL wb_match: got tag %0d sel %0d cycle %0d, expected tag %0d sel %0d cycle %0d",
                           bus.wb_tag_o, bus.wb_sel_o, cyc, e.tag, e.sel, e.cyc);
               else n_pass++;
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            $display("FAIL wb_missing: got no writeback at cycle %0d, expected tag %0d sel %0d",
                     cyc, e.tag, e.sel);
         end
      end
   end

   task automatic drive(input logic v, input logic mul, input logic red,
                        input logic [1:0] sew, input logic [TAG_W-1:0] tag);
      bus.issue_valid_i   = v;
      bus.issue_is_vmul_i = mul;
      bus.issue_is_vred_i = red;
      bus.issue_sew_i     = sew;
      bus.issue_tag_i     = tag;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.flush_i = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd11);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         @(negedge clk);
         n_total++;
         if (bus.issue_ready_o !== 1'b0 || bus.wb_valid_o !== 1'b0)
            $display("FAIL reset_hold: got ready %0b wb_valid %0b, expected 0 0",
                     bus.issue_ready_o, bus.wb_valid_o);
         else n_pass++;
      end
      next_cycle();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      @(negedge clk);
      n_total++;
      if (bus.wb_valid_o !== 1'b0 || bus.wb_sel_o !== 2'd0 || bus.wb_tag_o !== 7'd0 ||
          bus.busy_o !== 1'b0 || bus.inflight_o !== 2'd0 || bus.stall_cnt_o !== 32'd0)
         $display("FAIL reset_outputs: got wbv %0b sel %0d tag %0d busy %0b infl %0d stall %0d, expected all 0",
                  bus.wb_valid_o, bus.wb_sel_o, bus.wb_tag_o, bus.busy_o, bus.inflight_o, bus.stall_cnt_o);
      else n_pass++;
      n_total++;
      if (bus.issue_ready_o !== 1'b1)
         $display("FAIL reset_ready_after: got %0b expected 1", bus.issue_ready_o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         drive(1'b1, 1'b0, 1'b0, 2'b01, 7'(i));
         q.push_back('{tag: 7'(i), sel: 2'd0, cyc: cyc});
         @(negedge clk);
         n_total++;
         if (bus.issue_ready_o !== 1'b1)
            $display("FAIL b2b_ready: got %0b expected 1 for tag %0d", bus.issue_ready_o, i);
         else n_pass++;
      end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      @(negedge clk);
      n_total++;
      if (bus.stall_cnt_o !== 32'd0)
         $display("FAIL b2b_stall: got %0d expected 0", bus.stall_cnt_o);
      else n_pass++;
   endtask

   task automatic test_vmul64_vmul32();
      logic [CNT_W-1:0] base;
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b11, 7'd5);
      q.push_back('{tag: 7'd5, sel: 2'd2, cyc: cyc + 2});
      @(negedge clk);
      base = bus.stall_cnt_o;
      n_total++;
      if (bus.issue_ready_o !== 1'b1) $display("FAIL v64_t0_ready: got %0b expected 1", bus.issue_ready_o);
      else n_pass++;
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b10, 7'd6);
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b0) $display("FAIL v64_t1_ready: got %0b expected 0", bus.issue_ready_o);
      else n_pass++;
      next_cycle();
      q.push_back('{tag: 7'd6, sel: 2'd1, cyc: cyc + 1});
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b1) $display("FAIL v64_t2_ready: got %0b expected 1", bus.issue_ready_o);
      else n_pass++;
      n_total++;
      if (bus.stall_cnt_o !== base + 32'd1)
         $display("FAIL v64_stall: got %0d expected %0d", bus.stall_cnt_o, base + 32'd1);
      else n_pass++;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      repeat (2) next_cycle();
   endtask

   task automatic test_vred_add();
      logic [CNT_W-1:0] base;
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, 2'b00, 7'd9);
      q.push_back('{tag: 7'd9, sel: 2'd1, cyc: cyc + 1});
      @(negedge clk);
      base = bus.stall_cnt_o;
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd10);
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b0) $display("FAIL vred_t1_ready: got %0b expected 0", bus.issue_ready_o);
      else n_pass++;
      next_cycle();
      q.push_back('{tag: 7'd10, sel: 2'd0, cyc: cyc});
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b1 || bus.stall_cnt_o !== base + 32'd1)
         $display("FAIL vred_t2: got ready %0b stall %0d, expected 1 %0d",
                  bus.issue_ready_o, bus.stall_cnt_o, base + 32'd1);
      else n_pass++;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      next_cycle();
   endtask

   task automatic test_vmul64_sew8();
      logic [1:0] peak;
      peak = 2'd0;
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b11, 7'd3);
      q.push_back('{tag: 7'd3, sel: 2'd2, cyc: cyc + 2});
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b00, 7'd4);
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b0) $display("FAIL sew8_t1_ready: got %0b expected 0", bus.issue_ready_o);
      else n_pass++;
      if (bus.inflight_o > peak) peak = bus.inflight_o;
      next_cycle();
      q.push_back('{tag: 7'd4, sel: 2'd1, cyc: cyc + 1});
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b1) $display("FAIL sew8_t2_ready: got %0b expected 1", bus.issue_ready_o);
      else n_pass++;
      if (bus.inflight_o > peak) peak = bus.inflight_o;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      @(negedge clk);
      if (bus.inflight_o > peak) peak = bus.inflight_o;
      n_total++;
      if (peak !== 2'd1) $display("FAIL sew8_peak: got %0d expected 1", peak);
      else n_pass++;
      next_cycle();
      @(negedge clk);
      n_total++;
      if (bus.inflight_o !== 2'd0 || bus.busy_o !== 1'b0)
         $display("FAIL sew8_idle: got inflight %0d busy %0b, expected 0 0", bus.inflight_o, bus.busy_o);
      else n_pass++;
   endtask

   task automatic test_two_inflight();
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b11, 7'd20);
      q.push_back('{tag: 7'd20, sel: 2'd2, cyc: cyc + 2});
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b11, 7'd21);
      q.push_back('{tag: 7'd21, sel: 2'd2, cyc: cyc + 2});
      @(negedge clk);
      n_total++;
      if (bus.issue_ready_o !== 1'b1) $display("FAIL two_l3_ready: got %0b expected 1", bus.issue_ready_o);
      else n_pass++;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      @(negedge clk);
      n_total++;
      if (bus.inflight_o !== 2'd2 || bus.busy_o !== 1'b1 || bus.issue_ready_o !== 1'b0)
         $display("FAIL two_inflight: got inflight %0d busy %0b ready %0b, expected 2 1 0",
                  bus.inflight_o, bus.busy_o, bus.issue_ready_o);
      else n_pass++;
      repeat (2) next_cycle();
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] base;
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b11, 7'd7);
      @(negedge clk);
      base = bus.stall_cnt_o;
      next_cycle();
      bus.flush_i = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd8);
      @(negedge clk);
      n_total++;
      if (bus.wb_valid_o !== 1'b0 || bus.issue_ready_o !== 1'b0)
         $display("FAIL flush_t1: got wbv %0b ready %0b, expected 0 0", bus.wb_valid_o, bus.issue_ready_o);
      else n_pass++;
      next_cycle();
      bus.flush_i = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 2'b11, 7'd0);
      @(negedge clk);
      n_total++;
      if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.issue_ready_o !== 1'b1 ||
          bus.stall_cnt_o !== base)
         $display("FAIL flush_t2: got wbv %0b busy %0b ready %0b stall %0d, expected 0 0 1 %0d",
                  bus.wb_valid_o, bus.busy_o, bus.issue_ready_o, bus.stall_cnt_o, base);
      else n_pass++;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
   endtask

   task automatic test_reset_midop();
      mon_en = 1'b0;
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 2'b11, 7'd30);
      next_cycle();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if (bus.wb_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL reset_midop: got wbv %0b busy %0b at step %0d, expected 0 0",
                     bus.wb_valid_o, bus.busy_o, i);
         else n_pass++;
         next_cycle();
      end
      mon_en = 1'b1;
   endtask

   task automatic test_drain();
      repeat (4) next_cycle();
      @(negedge clk);
      n_total++;
      if (q.size() != 0) $display("FAIL drain: got %0d pending writebacks, expected 0", q.size());
      else n_pass++;
   endtask

   initial begin
      bus.flush_i = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd0);
      test_reset();
      mon_en = 1'b1;
      test_back_to_back();
      test_vmul64_vmul32();
      test_vred_add();
      test_vmul64_sew8();
      test_two_inflight();
      test_flush();
      test_reset_midop();
      test_drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
